// File: rtl/sram_block_ctrl_if.sv
// Bus bundle between the 68k-side decode logic and the SRAM block controller.
// The master side drives the address and strobes. The slave side returns the
// SRAM strobes, the block select and the handshake.
interface sram_block_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned NUM_BLOCKS = 4
);
  logic [ADDR_WIDTH-1:0] Address;
  logic                  SRamSelect_H;
  logic                  AS_L;
  logic                  UDS_L;
  logic                  LDS_L;
  logic                  WE_L;
  logic [NUM_BLOCKS-1:0] Block_H;
  logic                  SRam_CE_L;
  logic                  SRam_OE_L;
  logic                  SRam_WE_L;
  logic                  SRam_UB_L;
  logic                  SRam_LB_L;
  logic                  Dtack_L;
  logic                  Busy_H;

  modport master (
    output Address, SRamSelect_H, AS_L, UDS_L, LDS_L, WE_L,
    input  Block_H, SRam_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, Dtack_L, Busy_H
  );

  modport slave (
    input  Address, SRamSelect_H, AS_L, UDS_L, LDS_L, WE_L,
    output Block_H, SRam_CE_L, SRam_OE_L, SRam_WE_L, SRam_UB_L, SRam_LB_L, Dtack_L, Busy_H
  );
endinterface

// File: rtl/sram_block_ctrl.sv
// SRAM block controller. It registers a one-hot block select taken from the top
// address bits and runs the 68k bus cycle IDLE -> ACCESS -> ACK. Every SRAM
// strobe and Dtack_L is a registered output.
module sram_block_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 17,
  parameter int unsigned BLOCK_BITS  = 2,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic             Clk,
  input  logic             Reset_L,
  sram_block_ctrl_if.slave bus
);

  localparam int unsigned NUM_BLOCKS = 1 << BLOCK_BITS;
  localparam logic [3:0]  WaitLoad   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e                r_state;
  logic [3:0]            r_count;
  logic [NUM_BLOCKS-1:0] r_block;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  r_ub_n;
  logic                  r_lb_n;
  logic                  r_dtack_n;
  logic                  r_busy;

  logic                  w_start;
  logic                  w_cycle_end;
  logic [BLOCK_BITS-1:0] w_index;
  logic [NUM_BLOCKS-1:0] w_onehot;
  logic                  w_unused_addr;

  assign w_start     = bus.SRamSelect_H & ~bus.AS_L & (~bus.UDS_L | ~bus.LDS_L);
  // AS_L high ends the bus cycle. In ACCESS this is an abort, in ACK it is the normal close.
  assign w_cycle_end = (r_state != StIdle) & bus.AS_L;
  assign w_index     = bus.Address[ADDR_WIDTH-1 -: BLOCK_BITS];

  // The low address bits belong to the SRAM chips themselves, not to the block decode.
  assign w_unused_addr = ^bus.Address[ADDR_WIDTH-BLOCK_BITS-1:0];

  // Decode the block index into a one-hot select.
  always_comb begin
    w_onehot          = '0;
    w_onehot[w_index] = 1'b1;
  end

  // Bus-cycle sequencer that drives all registered strobes, the block select and the wait counter.
  always_ff @(posedge Clk) begin
    if (!Reset_L || w_cycle_end) begin
      r_state   <= StIdle;
      r_count   <= 4'd0;
      r_block   <= '0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_ub_n    <= 1'b1;
      r_lb_n    <= 1'b1;
      r_dtack_n <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_state <= StAccess;
            r_count <= WaitLoad;
            r_block <= w_onehot;
            r_ce_n  <= 1'b0;
            // Read/write direction is fixed for the whole cycle, so OE and WE can never overlap.
            r_oe_n  <= ~bus.WE_L;
            r_we_n  <= bus.WE_L;
            r_ub_n  <= bus.UDS_L;
            r_lb_n  <= bus.LDS_L;
            r_busy  <= 1'b1;
          end
        end
        StAccess: begin
          r_ub_n <= bus.UDS_L;
          r_lb_n <= bus.LDS_L;
          if (r_count == 4'd0) begin
            r_state   <= StAck;
            r_dtack_n <= 1'b0;
            // Release WE one cycle before the 68k drops its data (write data hold).
            r_we_n    <= 1'b1;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        StAck: begin
          r_ub_n <= bus.UDS_L;
          r_lb_n <= bus.LDS_L;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.Block_H   = r_block;
  assign bus.SRam_CE_L = r_ce_n;
  assign bus.SRam_OE_L = r_oe_n;
  assign bus.SRam_WE_L = r_we_n;
  assign bus.SRam_UB_L = r_ub_n;
  assign bus.SRam_LB_L = r_lb_n;
  assign bus.Dtack_L   = r_dtack_n;
  assign bus.Busy_H    = r_busy;

  a_strobe_excl: assert property (@(posedge Clk) disable iff (!Reset_L) (r_oe_n | r_we_n));
  a_block_onehot0: assert property (@(posedge Clk) disable iff (!Reset_L) $onehot0(r_block));

endmodule

// File: tb/tb_sram_block_ctrl.sv
// Bench for sram_block_ctrl. Four instances run from the same stimulus:
// u0 = defaults (17/2/1), u1 = no wait states, u2 = three wait states, u3 = 18-bit / 3 block bits.
// Each instance is compared against a cycle-count reference model.
module tb_sram_block_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] addr;
  logic        sel, as_n, uds_n, lds_n, we_n;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sram_block_ctrl_if #(.ADDR_WIDTH(17), .NUM_BLOCKS(4)) if0 ();
  sram_block_ctrl_if #(.ADDR_WIDTH(17), .NUM_BLOCKS(4)) if1 ();
  sram_block_ctrl_if #(.ADDR_WIDTH(17), .NUM_BLOCKS(4)) if2 ();
  sram_block_ctrl_if #(.ADDR_WIDTH(18), .NUM_BLOCKS(8)) if3 ();

  assign if0.Address = addr[16:0];
  assign if1.Address = addr[16:0];
  assign if2.Address = addr[16:0];
  assign if3.Address = addr;
  assign if0.SRamSelect_H = sel;  assign if0.AS_L = as_n;  assign if0.WE_L = we_n;
  assign if1.SRamSelect_H = sel;  assign if1.AS_L = as_n;  assign if1.WE_L = we_n;
  assign if2.SRamSelect_H = sel;  assign if2.AS_L = as_n;  assign if2.WE_L = we_n;
  assign if3.SRamSelect_H = sel;  assign if3.AS_L = as_n;  assign if3.WE_L = we_n;
  assign if0.UDS_L = uds_n;  assign if0.LDS_L = lds_n;
  assign if1.UDS_L = uds_n;  assign if1.LDS_L = lds_n;
  assign if2.UDS_L = uds_n;  assign if2.LDS_L = lds_n;
  assign if3.UDS_L = uds_n;  assign if3.LDS_L = lds_n;

  sram_block_ctrl #(.ADDR_WIDTH(17), .BLOCK_BITS(2), .WAIT_STATES(1)) u_dut0 (
    .Clk(clk), .Reset_L(rst_n), .bus(if0)
  );
  sram_block_ctrl #(.ADDR_WIDTH(17), .BLOCK_BITS(2), .WAIT_STATES(0)) u_dut1 (
    .Clk(clk), .Reset_L(rst_n), .bus(if1)
  );
  sram_block_ctrl #(.ADDR_WIDTH(17), .BLOCK_BITS(2), .WAIT_STATES(3)) u_dut2 (
    .Clk(clk), .Reset_L(rst_n), .bus(if2)
  );
  sram_block_ctrl #(.ADDR_WIDTH(18), .BLOCK_BITS(3), .WAIT_STATES(2)) u_dut3 (
    .Clk(clk), .Reset_L(rst_n), .bus(if3)
  );

  // Observed outputs: {Block_H (8b), CE, OE, WE, UB, LB, Dtack, Busy}
  logic [14:0] obs [4];
  assign obs[0] = {4'h0, if0.Block_H, if0.SRam_CE_L, if0.SRam_OE_L, if0.SRam_WE_L,
                   if0.SRam_UB_L, if0.SRam_LB_L, if0.Dtack_L, if0.Busy_H};
  assign obs[1] = {4'h0, if1.Block_H, if1.SRam_CE_L, if1.SRam_OE_L, if1.SRam_WE_L,
                   if1.SRam_UB_L, if1.SRam_LB_L, if1.Dtack_L, if1.Busy_H};
  assign obs[2] = {4'h0, if2.Block_H, if2.SRam_CE_L, if2.SRam_OE_L, if2.SRam_WE_L,
                   if2.SRam_UB_L, if2.SRam_LB_L, if2.Dtack_L, if2.Busy_H};
  assign obs[3] = {if3.Block_H, if3.SRam_CE_L, if3.SRam_OE_L, if3.SRam_WE_L,
                   if3.SRam_UB_L, if3.SRam_LB_L, if3.Dtack_L, if3.Busy_H};

  // Strobe patterns {CE, OE, WE, UB, LB, Dtack, Busy}
  localparam logic [6:0] S_IDLE   = 7'b111_1110;
  localparam logic [6:0] S_RD     = 7'b001_0011;  // read, both lanes, waiting
  localparam logic [6:0] S_RD_ACK = 7'b001_0001;  // read, both lanes, acknowledged
  localparam logic [6:0] S_WR     = 7'b010_1011;  // write, lower lane, WE low
  localparam logic [6:0] S_WR_ACK = 7'b011_1001;  // write, lower lane, hold cycle

  // ---------------- reference model ----------------
  function automatic int ws_of(int i);
    case (i)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int aw_of(int i);
    return (i == 3) ? 18 : 17;
  endfunction

  function automatic int bb_of(int i);
    return (i == 3) ? 3 : 2;
  endfunction

  function automatic int blk_of(int i, logic [17:0] a);
    int v;
    v = int'(a) % (1 << aw_of(i));
    return v / (1 << (aw_of(i) - bb_of(i)));
  endfunction

  // m_k counts edges since the start edge. ACCESS covers k = 0..WS, and ACK follows.
  bit m_act [4];
  int m_k   [4];
  int m_blk [4];
  bit m_rd  [4];
  bit m_ub  [4];
  bit m_lb  [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0;
        m_k[i]   <= 0;
      end else if (!m_act[i]) begin
        if (sel && !as_n && (!uds_n || !lds_n)) begin
          m_act[i] <= 1'b1;
          m_k[i]   <= 0;
          m_blk[i] <= blk_of(i, addr);
          m_rd[i]  <= we_n;
          m_ub[i]  <= uds_n;
          m_lb[i]  <= lds_n;
        end
      end else if (as_n) begin
        m_act[i] <= 1'b0;
      end else begin
        m_k[i]  <= (m_k[i] < 64) ? m_k[i] + 1 : m_k[i];
        m_ub[i] <= uds_n;
        m_lb[i] <= lds_n;
      end
    end
  end

  function automatic logic [14:0] model_out(int i);
    logic [7:0] b;
    bit ack, acc;
    b   = m_act[i] ? 8'(1 << m_blk[i]) : 8'h00;
    ack = m_act[i] && (m_k[i] > ws_of(i));
    acc = m_act[i] && !ack;
    return {b, !m_act[i], !(m_act[i] && m_rd[i]), !(acc && !m_rd[i]),
            m_act[i] ? m_ub[i] : 1'b1, m_act[i] ? m_lb[i] : 1'b1, !ack, m_act[i]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic go_idle();
    sel = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; we_n = 1'b1;
    step();
    step();
  endtask

  task automatic start_read(input logic [17:0] a);
    addr = a; sel = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; we_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs[i] !== {8'h00, S_IDLE}) begin
        n_fail++; $display("FAIL reset_init u%0d: got %b exp %b", i, obs[i], {8'h00, S_IDLE});
      end
    end
    rst_n = 1'b1;
    start_read(18'h00000);
    step();
    n_cmp++;
    if (obs[2] !== {8'h01, S_RD}) begin
      n_fail++; $display("FAIL reset_pre_access: got %b exp %b", obs[2], {8'h01, S_RD});
    end
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs[i] !== {8'h00, S_IDLE}) begin
        n_fail++; $display("FAIL reset_mid_access u%0d: got %b exp %b", i, obs[i], {8'h00, S_IDLE});
      end
    end
    as_n = 1'b1; sel = 1'b0; rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs[2] !== {8'h00, S_IDLE}) begin
      n_fail++; $display("FAIL reset_release: got %b exp %b", obs[2], {8'h00, S_IDLE});
    end
  endtask

  task automatic test_read();
    go_idle();
    start_read(18'h18000);
    step();
    n_cmp++;
    if (obs[0] !== {8'h08, S_RD}) begin
      n_fail++; $display("FAIL read_edge1: got %b exp %b", obs[0], {8'h08, S_RD});
    end
    sel = 1'b0;  // deselect after start must not matter
    step();
    n_cmp++;
    if (obs[0] !== {8'h08, S_RD}) begin
      n_fail++; $display("FAIL read_edge2: got %b exp %b", obs[0], {8'h08, S_RD});
    end
    step();
    n_cmp++;
    if (obs[0] !== {8'h08, S_RD_ACK}) begin
      n_fail++; $display("FAIL read_dtack_edge3: got %b exp %b", obs[0], {8'h08, S_RD_ACK});
    end
    step();
    n_cmp++;
    if (obs[0] !== {8'h08, S_RD_ACK}) begin
      n_fail++; $display("FAIL read_ack_hold: got %b exp %b", obs[0], {8'h08, S_RD_ACK});
    end
    as_n = 1'b1;
    step();
    n_cmp++;
    if (obs[0] !== {8'h00, S_IDLE}) begin
      n_fail++; $display("FAIL read_close: got %b exp %b", obs[0], {8'h00, S_IDLE});
    end
  endtask

  task automatic test_write();
    go_idle();
    addr = 18'h08002; sel = 1'b1; as_n = 1'b0; uds_n = 1'b1; lds_n = 1'b0; we_n = 1'b0;
    step();
    n_cmp++;
    if (obs[1] !== {8'h02, S_WR}) begin
      n_fail++; $display("FAIL write_edge1: got %b exp %b", obs[1], {8'h02, S_WR});
    end
    step();
    n_cmp++;
    if (obs[1] !== {8'h02, S_WR_ACK}) begin
      n_fail++; $display("FAIL write_dtack_edge2: got %b exp %b", obs[1], {8'h02, S_WR_ACK});
    end
    as_n = 1'b1;
    step();
    n_cmp++;
    if (obs[1] !== {8'h00, S_IDLE}) begin
      n_fail++; $display("FAIL write_close: got %b exp %b", obs[1], {8'h00, S_IDLE});
    end
  endtask

  task automatic test_abort();
    go_idle();
    start_read(18'h00000);
    for (int e = 1; e <= 3; e++) begin
      step();
      n_cmp++;
      if (obs[2] !== {8'h01, S_RD}) begin
        n_fail++; $display("FAIL abort_access_e%0d: got %b exp %b", e, obs[2], {8'h01, S_RD});
      end
    end
    as_n = 1'b1;
    for (int e = 0; e < 2; e++) begin
      step();
      n_cmp++;
      if (obs[2] !== {8'h00, S_IDLE}) begin
        n_fail++; $display("FAIL abort_idle_%0d: got %b exp %b", e, obs[2], {8'h00, S_IDLE});
      end
    end
  endtask

  task automatic test_sweep();
    go_idle();
    addr = 18'h30000; sel = 1'b0; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; we_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      n_cmp++;
      if (obs[0] !== {8'h00, S_IDLE}) begin
        n_fail++; $display("FAIL nosel_%0d: got %b exp %b", e, obs[0], {8'h00, S_IDLE});
      end
    end
    sel = 1'b1;
    step();
    n_cmp++;
    if (obs[3] !== {8'h40, S_RD}) begin
      n_fail++; $display("FAIL sweep_u3_block: got %b exp %b", obs[3], {8'h40, S_RD});
    end
    n_cmp++;
    if (obs[0] !== {8'h04, S_RD}) begin
      n_fail++; $display("FAIL sweep_u0_block: got %b exp %b", obs[0], {8'h04, S_RD});
    end
    as_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    go_idle();
    start_read(18'h18000);
    step();
    step();
    step();
    n_cmp++;
    if (obs[0] !== {8'h08, S_RD_ACK}) begin
      n_fail++; $display("FAIL b2b_first_ack: got %b exp %b", obs[0], {8'h08, S_RD_ACK});
    end
    as_n = 1'b1;
    step();
    n_cmp++;
    if (obs[0] !== {8'h00, S_IDLE}) begin
      n_fail++; $display("FAIL b2b_idle_gap: got %b exp %b", obs[0], {8'h00, S_IDLE});
    end
    as_n = 1'b0;
    step();
    n_cmp++;
    if (obs[0] !== {8'h08, S_RD}) begin
      n_fail++; $display("FAIL b2b_second_access: got %b exp %b", obs[0], {8'h08, S_RD});
    end
    as_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    int as_run;
    go_idle();
    as_run = 0;
    for (int c = 0; c < 600; c++) begin
      if (as_run == 0) begin
        as_n   = ~as_n;
        as_run = as_n ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 8));
      end
      as_run--;
      sel   = ($urandom_range(0, 3) != 0);
      uds_n = ($urandom_range(0, 2) == 0);
      lds_n = ($urandom_range(0, 2) == 0);
      we_n  = 1'($urandom_range(0, 1));
      addr  = 18'($urandom);
      rst_n = ($urandom_range(0, 60) != 0);
      step();
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs[i] !== model_out(i)) begin
          n_fail++;
          $display("FAIL random c%0d u%0d: got %b exp %b", c, i, obs[i], model_out(i));
        end
      end
    end
    rst_n = 1'b1;
    go_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = '0;
    sel   = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; we_n = 1'b1;
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_sweep();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
